sc_mux_add_param: RTL and testbench
===================================

Name: sc_mux_add_param

Overview:
- Parametrised stochastic-computing scaled adder: N unipolar input bitstreams in, one output stream out.
- Output stream value = (1/NUM_IN)·Σ p_i.
- Successor to the fixed-width mux adder. Adds:
  - selectable select-sequence generator (binary counter or bit-reversed/van der Corput counter);
  - programmable select hold period and seed;
  - bounded stream length with start/done handshake;
  - on-block ones counter for the output stream.
- Sits between SNG banks and downstream SC arithmetic or a stream-to-binary counter.

Parameters:
- NUM_IN, 8, number of input streams; power of two, ≥2.
- LOG_IN, $clog2(NUM_IN), select width; derived, not overridden.
- LEN_W, 8, stream length field; max stream length 2^LEN_W.
- SEL_MODE, 1, select sequence: 0 = binary up-counter; 1 = bit-reversed counter (Sobol dim-1 order).
- HOLD, 1, number of consecutive output bits per select value; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle request to begin a stream; honoured only in IDLE.
- len  in  LEN_W+1  stream length in cycles (0..2^LEN_W), captured on start.
- seed_load  in  1  load seed into seed register (any state).
- seed  in  LOG_IN  initial select counter value.
- in  in  NUM_IN  current bit of each input stream.
- out  out  1  registered output stream bit.
- out_valid  out  1  out carries a stream bit.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse at stream end.
- ones_cnt  out  LEN_W+1  number of 1s emitted in current/last stream.

Behaviour:
- Reset: rst_n low at an edge → state IDLE. All of these clear to 0: out, out_valid, done, ones_cnt, seed_reg, sel counter, hold counter, cycle counter. Reset mid-run aborts with no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE → RUN: start=1 at edge E0 with len≠0. Captures len. Loads ctr = (seed_load ? seed : seed_reg). Clears hold_cnt, cyc and ones_cnt.
- IDLE → FIN: start=1 with len=0. No valid bits are produced.
- RUN, each edge:
  - out ← in[sel], out_valid ← 1, ones_cnt += in[sel], cyc += 1.
  - sel = ctr for SEL_MODE=0; sel = bit-reverse(ctr) for SEL_MODE=1.
  - hold_cnt increments. When hold_cnt = HOLD-1 it wraps to 0 and ctr ← ctr+1 mod NUM_IN.
  - When cyc reaches len → FIN.
- FIN, one edge: out_valid ← 0, out ← 0, done ← 1, → IDLE. done is deasserted on the following edge.
- Latency: `in` sampled in the cycle after E0 appears on out after E1. out_valid is high exactly len cycles (after E1..E_len). done is high after E_{len+1}.
- busy is high from after E0 until done is asserted; it is low in the done cycle.
- start in RUN/FIN is ignored.
- seed_load in any state updates seed_reg. A seed loaded during RUN affects only the next run. Simultaneous start+seed_load uses the new seed.
- ones_cnt holds its value after done until the next start. It cannot overflow: len ≤ 2^LEN_W.
- Select counter wraps naturally mod NUM_IN. After NUM_IN·HOLD cycles every input has been selected HOLD times.

Decomposition:
- Package sc_pkg holds:
  - sel_mode_e enum (SEL_BIN, SEL_BITREV);
  - state_e enum (IDLE, RUN, FIN);
  - bit-reverse function, parametrised by width.
- One sub-module, sc_sel_gen: holds ctr, hold_cnt and mode mapping. Ports: clk, rst_n, init, init_val, advance, sel.
- Mux, FSM and counters stay in the top module.

Test Plan:
- NUM_IN=8, SEL_MODE=0, HOLD=1, in=8'h0F, seed=0, len=16 → out = 1111_0000_1111_0000; ones_cnt=8; out_valid 16 cycles; done 17 edges after E0.
- SEL_MODE=1, in=8'h0F, seed=0, len=8 → sel 0,4,2,6,1,5,3,7 → out = 1,0,1,0,1,0,1,0; ones_cnt=4.
- SEL_MODE=0, HOLD=2, in=8'h01, seed=0, len=16 → out = 1,1 then fourteen 0s; ones_cnt=2. Repeat with seed_load seed=7 simultaneous with start → first 1 appears at output bits 2,3.
- len=0 → no out_valid; done pulses after E1; busy high for exactly one cycle; ones_cnt=0.
- start pulsed during RUN (len=16) → ignored: still exactly 16 valid bits and one done pulse.
- rst_n low for one cycle at cycle 5 of a len=16 run → next cycle all outputs 0, state IDLE, no done pulse. A new start then runs normally with seed_reg=0.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing mux adder.
// Select-mode and FSM encodings plus a width-parametrised bit reversal.
package sc_pkg;

  typedef enum logic {
    SEL_BIN    = 1'b0,
    SEL_BITREV = 1'b1
  } sel_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Reverses the low w bits of v; bits at and above w return 0.
  function automatic logic [31:0] bit_rev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_sel_gen.sv
// Select-sequence generator: counter with hold period and
// optional bit-reversed (van der Corput) output ordering.
module sc_sel_gen
  import sc_pkg::*;
#(
  parameter int LOG_IN   = 3,
  parameter int SEL_MODE = 1,
  parameter int HOLD     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic [LOG_IN-1:0] init_val,
  input  logic              advance,
  output logic [LOG_IN-1:0] sel
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);
  localparam logic [LOG_IN-1:0] CTR_ONE = LOG_IN'(1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  logic [LOG_IN-1:0] ctr;
  logic [HW-1:0]     hold_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr      <= '0;
      hold_cnt <= '0;
    end else if (init) begin
      ctr      <= init_val;
      hold_cnt <= '0;
    end else if (advance) begin
      if (hold_cnt == HOLD_MAX) begin
        hold_cnt <= '0;
        ctr      <= ctr + CTR_ONE;
      end else begin
        hold_cnt <= hold_cnt + HOLD_ONE;
      end
    end
  end

  assign sel = (SEL_MODE == int'(SEL_BITREV))
             ? LOG_IN'(bit_rev(32'(ctr), LOG_IN))
             : ctr;

endmodule

// File: rtl/sc_mux_add_param.sv
// Parametrised SC scaled adder: muxes NUM_IN unipolar streams
// into one output stream of bounded length with a ones counter.
module sc_mux_add_param
  import sc_pkg::*;
#(
  parameter int NUM_IN   = 8,
  parameter int LOG_IN   = $clog2(NUM_IN),
  parameter int LEN_W    = 8,
  parameter int SEL_MODE = 1,
  parameter int HOLD     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W:0]    len,
  input  logic              seed_load,
  input  logic [LOG_IN-1:0] seed,
  input  logic [NUM_IN-1:0] in,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [LEN_W:0]    ones_cnt
);

  localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);

  state_e            state;
  logic [LEN_W:0]    len_q;
  logic [LEN_W:0]    cyc;
  logic [LOG_IN-1:0] seed_reg;
  logic [LOG_IN-1:0] sel;
  logic              init;
  logic              bit_sel;

  // A seed arriving together with start takes effect immediately.
  assign init    = (state == IDLE) && start;
  assign bit_sel = in[sel];
  assign busy    = (state != IDLE);

  sc_sel_gen #(
    .LOG_IN  (LOG_IN),
    .SEL_MODE(SEL_MODE),
    .HOLD    (HOLD)
  ) u_sel_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (init),
    .init_val(seed_load ? seed : seed_reg),
    .advance (state == RUN),
    .sel     (sel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      cyc       <= '0;
      seed_reg  <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      ones_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (seed_load) seed_reg <= seed;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            cyc      <= '0;
            ones_cnt <= '0;
            state    <= (len == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          out       <= bit_sel;
          out_valid <= 1'b1;
          ones_cnt  <= ones_cnt + {{LEN_W{1'b0}}, bit_sel};
          cyc       <= cyc + ONE;
          if (cyc + ONE == len_q) state <= FIN;
        end
        FIN: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_mux_add_param.sv
// Scoreboard bench: three DUT configurations share one stimulus
// stream; an arithmetic model predicts every output bit.
module tb_sc_mux_add_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] len_i;
  logic       seed_load;
  logic [2:0] seed;
  logic [7:0] in_i;

  logic       dout  [3];
  logic       dvalid[3];
  logic       dbusy [3];
  logic       ddone [3];
  logic [8:0] dones [3];

  logic exp_q[3][$];
  int   vcount[3];
  int   done_seen[3];
  int   done_exp;
  int   seed_m;
  int   total;
  int   passed;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sc_mux_add_param #(
      .NUM_IN  (8),
      .LEN_W   (8),
      .SEL_MODE((g == 1) ? 1 : 0),
      .HOLD    ((g == 2) ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .len      (len_i),
      .seed_load(seed_load),
      .seed     (seed),
      .in       (in_i),
      .out      (dout[g]),
      .out_valid(dvalid[g]),
      .busy     (dbusy[g]),
      .done     (ddone[g]),
      .ones_cnt (dones[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int mode_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int hold_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic int rev3(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < 3; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Bit k of a stream: input chosen by (seed + k/HOLD) mod 8, optionally reversed.
  function automatic logic model_bit(input int i, input int s, input int k,
                                     input logic [7:0] v);
    int c;
    int idx;
    c   = (s + k / hold_of(i)) % 8;
    idx = (mode_of(i) == 1) ? rev3(c) : c;
    return v[idx];
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ddone[i]) done_seen[i]++;
      if (dvalid[i]) begin
        vcount[i]++;
        if (exp_q[i].size() == 0) begin
          chk($sformatf("extra_bit_dut%0d", i), 1, 0);
        end else begin
          chk($sformatf("out_dut%0d", i), int'(dout[i]),
              int'(exp_q[i].pop_front()));
        end
      end
    end
  end

  task automatic run(input int n, input bit sl, input int sd,
                     input bit rnd, input logic [7:0] pat, input bit mid);
    int ones[3];
    int eff;
    logic b;
    @(negedge clk);
    start = 1'b1;
    len_i = 9'(n);
    seed_load = sl;
    seed = 3'(sd);
    if (sl) seed_m = sd;
    eff = seed_m;
    for (int i = 0; i < 3; i++) begin
      vcount[i] = 0;
      ones[i] = 0;
    end
    @(negedge clk);
    start = 1'b0;
    seed_load = 1'b0;
    for (int i = 0; i < 3; i++) chk("busy_after_start", int'(dbusy[i]), 1);
    for (int k = 0; k < n; k++) begin
      in_i = rnd ? 8'($urandom) : pat;
      start = 1'b0;
      seed_load = 1'b0;
      if (mid && k == 3) begin
        start = 1'b1;
        len_i = 9'd5;
        seed_load = 1'b1;
        seed = 3'($urandom_range(0, 7));
        seed_m = int'(seed);
      end
      for (int i = 0; i < 3; i++) begin
        b = model_bit(i, eff, k, in_i);
        exp_q[i].push_back(b);
        ones[i] += int'(b);
      end
      @(negedge clk);
    end
    start = 1'b0;
    seed_load = 1'b0;
    @(negedge clk);
    done_exp++;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("done_dut%0d_len%0d", i, n), int'(ddone[i]), 1);
      chk("busy_in_done", int'(dbusy[i]), 0);
      chk("valid_in_done", int'(dvalid[i]), 0);
      chk($sformatf("ones_dut%0d_len%0d", i, n), int'(dones[i]), ones[i]);
      chk($sformatf("valid_count_dut%0d", i), vcount[i], n);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("done_one_cycle", int'(ddone[i]), 0);
      chk("ones_held", int'(dones[i]), ones[i]);
    end
  endtask

  task automatic reset_check(input string name);
    for (int i = 0; i < 3; i++) begin
      chk({name, "_out"}, int'(dout[i]), 0);
      chk({name, "_valid"}, int'(dvalid[i]), 0);
      chk({name, "_busy"}, int'(dbusy[i]), 0);
      chk({name, "_done"}, int'(ddone[i]), 0);
      chk({name, "_ones"}, int'(dones[i]), 0);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    start = 1'b1;
    len_i = 9'd16;
    seed_load = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_i = 8'($urandom);
      for (int i = 0; i < 3; i++)
        exp_q[i].push_back(model_bit(i, seed_m, k, in_i));
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seed_m = 0;
    reset_check("mid_reset");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("idle_after_reset", int'(dbusy[i]), 0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    done_exp = 0;
    seed_m = 0;
    for (int i = 0; i < 3; i++) begin
      vcount[i] = 0;
      done_seen[i] = 0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    len_i = '0;
    seed_load = 1'b0;
    seed = '0;
    in_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_check("reset");

    run(16, 1'b0, 0, 1'b0, 8'h0F, 1'b0);
    run(8, 1'b0, 0, 1'b0, 8'h0F, 1'b0);
    run(16, 1'b0, 0, 1'b0, 8'h01, 1'b0);
    run(16, 1'b1, 7, 1'b0, 8'h01, 1'b0);
    run(0, 1'b0, 0, 1'b0, 8'hFF, 1'b0);
    run(16, 1'b0, 0, 1'b1, 8'h00, 1'b1);
    run(12, 1'b0, 0, 1'b1, 8'h00, 1'b0);
    mid_reset();
    run(16, 1'b0, 0, 1'b1, 8'h00, 1'b0);
    run(256, 1'b0, 0, 1'b0, 8'hFF, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run($urandom_range(1, 40), 1'($urandom), $urandom_range(0, 7),
          1'b1, 8'h00, 1'($urandom));
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("queue_drained_dut%0d", i), exp_q[i].size(), 0);
      chk($sformatf("done_pulses_dut%0d", i), done_seen[i], done_exp);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
